// File: rtl/tmp_bitstream_decimator.sv
// Sigma-delta bitstream decimator for the temperature sensor loop.
// Optional second integrator (sinc2) enabled by defining TMP_DEC_CIC2_EN.
module tmp_bitstream_decimator #(
    parameter int OSR_LOG2   = 6,
    parameter int CONTINUOUS = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    bit_stb,
    input  logic                    src_n,
    input  logic                    snk,
    output logic [2*OSR_LOG2+1:0]   code,
    output logic                    code_valid,
    input  logic                    code_ready,
    output logic                    busy,
    output logic                    err,
    output logic                    ovf
);

    localparam int AW = OSR_LOG2 + 2;
    localparam int CW = 2 * OSR_LOG2 + 2;
    localparam logic signed [AW-1:0] ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic signed [AW-1:0] acc1;
    logic signed [AW-1:0] acc1_next;
    logic [OSR_LOG2-1:0]  cnt;
    logic signed [CW-1:0] result;
    logic                 take;
    logic                 last;
    logic                 clr;
    logic                 d_pos;
    logic                 d_neg;
    logic                 d_ill;
    logic                 load;

    // Decode the sample decision and the post-update first integrator.
    always_comb begin
        take      = (state == RUN) && bit_stb;
        d_pos     = !src_n && !snk;
        d_neg     = src_n && snk;
        d_ill     = !src_n && snk;
        last      = take && (cnt == '1);
        clr       = ((state == IDLE) && start) ||
                    ((state == DONE) && (CONTINUOUS != 0));
        load      = !code_valid || code_ready;
        acc1_next = acc1;
        if (d_pos) begin
            acc1_next = acc1 + ONE;
        end else if (d_neg) begin
            acc1_next = acc1 - ONE;
        end
    end

`ifdef TMP_DEC_CIC2_EN
    logic signed [CW-1:0] acc2;
    logic signed [CW-1:0] acc2_next;

    // Second integrator accumulates the running first-integrator value.
    always_comb begin
        acc2_next = acc2 + {{(CW-AW){acc1_next[AW-1]}}, acc1_next};
    end

    // Second integrator register, cleared with the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc2 <= '0;
        end else if (clr) begin
            acc2 <= '0;
        end else if (take) begin
            acc2 <= acc2_next;
        end
    end

    assign result = acc2;
`else
    assign result = {{(CW-AW){acc1[AW-1]}}, acc1};
`endif

    // Window FSM with first integrator, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc1       <= '0;
            cnt        <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (code_valid && code_ready) begin
                code_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc1  <= '0;
                        cnt   <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (take) begin
                        acc1 <= acc1_next;
                        cnt  <= cnt + 1'b1;
                        if (d_ill) begin
                            err <= 1'b1;
                        end
                        if (last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (load) begin
                        code       <= result;
                        code_valid <= 1'b1;
                    end else begin
                        ovf <= 1'b1;
                    end
                    if (CONTINUOUS != 0) begin
                        acc1  <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmp_bitstream_decimator.sv
// Self-checking bench for tmp_bitstream_decimator.
// Three instances: OSR 4 one-shot, OSR 64 one-shot, OSR 4 continuous.
module tb_tmp_bitstream_decimator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  start = '0;
    logic [2:0]  stb = '0;
    logic [2:0]  src_n = '1;
    logic [2:0]  snk = '0;
    logic [2:0]  rdy = '0;
    logic [2:0]  valid;
    logic [2:0]  busy;
    logic [2:0]  err;
    logic [2:0]  ovf;
    logic [5:0]  code0;
    logic [13:0] code1;
    logic [5:0]  code2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tmp_bitstream_decimator #(.OSR_LOG2(2), .CONTINUOUS(0)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .bit_stb(stb[0]),
        .src_n(src_n[0]), .snk(snk[0]), .code(code0),
        .code_valid(valid[0]), .code_ready(rdy[0]), .busy(busy[0]),
        .err(err[0]), .ovf(ovf[0])
    );

    tmp_bitstream_decimator #(.OSR_LOG2(6), .CONTINUOUS(0)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .bit_stb(stb[1]),
        .src_n(src_n[1]), .snk(snk[1]), .code(code1),
        .code_valid(valid[1]), .code_ready(rdy[1]), .busy(busy[1]),
        .err(err[1]), .ovf(ovf[1])
    );

    tmp_bitstream_decimator #(.OSR_LOG2(2), .CONTINUOUS(1)) u2 (
        .clk(clk), .reset(reset), .start(start[2]), .bit_stb(stb[2]),
        .src_n(src_n[2]), .snk(snk[2]), .code(code2),
        .code_valid(valid[2]), .code_ready(rdy[2]), .busy(busy[2]),
        .err(err[2]), .ovf(ovf[2])
    );

    // Reference: d = 2 marks an illegal sample (contributes zero).
    function automatic int model(input int d[$]);
        int a1 = 0;
        int a2 = 0;
        foreach (d[i]) begin
            a1 += (d[i] == 2) ? 0 : d[i];
            a2 += a1;
        end
`ifdef TMP_DEC_CIC2_EN
        return a2;
`else
        return a1;
`endif
    endfunction

    function automatic int get_code(input int u);
        case (u)
            0:       return int'($signed(code0));
            1:       return int'($signed(code1));
            default: return int'($signed(code2));
        endcase
    endfunction

    function automatic int rand_d();
        return int'($urandom_range(0, 2)) - 1;
    endfunction

    // Called at a negedge; returns at the next negedge with strobe low.
    task automatic drive_stb(input int u, input int d);
        stb[u] = 1'b1;
        case (d)
            1:       begin src_n[u] = 1'b0; snk[u] = 1'b0; end
            -1:      begin src_n[u] = 1'b1; snk[u] = 1'b1; end
            0:       begin src_n[u] = 1'b1; snk[u] = 1'b0; end
            default: begin src_n[u] = 1'b0; snk[u] = 1'b1; end
        endcase
        @(negedge clk);
        stb[u] = 1'b0;
        src_n[u] = 1'b1;
        snk[u] = 1'b0;
    endtask

    task automatic pulse_start(input int u);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
    endtask

    // Returns in the cycle after the last strobe (DONE cycle).
    task automatic run_window(input int u, input int q[$], input int maxgap);
        foreach (q[i]) begin
            drive_stb(u, q[i]);
            if (i != q.size() - 1) begin
                repeat ($urandom_range(1, maxgap)) @(negedge clk);
            end
        end
    endtask

    task automatic consume(input int u);
        rdy[u] = 1'b1;
        @(negedge clk);
        rdy[u] = 1'b0;
        checks++;
        if (valid[u] !== 1'b0) begin
            errors++;
            $display("FAIL consume_drop u%0d: valid=%b want 0", u, valid[u]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (valid[u] !== 1'b0 || busy[u] !== 1'b0 ||
                err[u] !== 1'b0 || ovf[u] !== 1'b0 || get_code(u) !== 0) begin
                errors++;
                $display("FAIL reset_state u%0d: v=%b b=%b e=%b o=%b code=%0d want all 0",
                         u, valid[u], busy[u], err[u], ovf[u], get_code(u));
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int q[$] = '{1, 1, 1, 1};
        int exp = model(q);
        pulse_start(0);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_rise: busy=%b want 1", busy[0]);
        end
        run_window(0, q, 2);
        checks++;
        if (valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_cycle: valid=%b busy=%b want 0 1", valid[0], busy[0]);
        end
        @(negedge clk);
        checks++;
        if (valid[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_timing: valid=%b busy=%b want 1 0", valid[0], busy[0]);
        end
        checks++;
        if (get_code(0) !== exp) begin
            errors++;
            $display("FAIL basic_code: got %0d want %0d", get_code(0), exp);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (valid[0] !== 1'b1 || get_code(0) !== exp) begin
            errors++;
            $display("FAIL basic_hold: valid=%b code=%0d want 1 %0d", valid[0], get_code(0), exp);
        end
        consume(0);
    endtask

    task automatic test_illegal();
        int q[$] = '{1, 1, 2, 1};
        int z[$] = '{0, 0, 0, 0};
        int exp = model(q);
        pulse_start(0);
        run_window(0, q, 1);
        @(negedge clk);
        checks++;
        if (get_code(0) !== exp || err[0] !== 1'b1) begin
            errors++;
            $display("FAIL illegal_code_err: code=%0d err=%b want %0d 1", get_code(0), err[0], exp);
        end
        consume(0);
        checks++;
        if (err[0] !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: err=%b want 1", err[0]);
        end
        pulse_start(0);
        checks++;
        if (err[0] !== 1'b0) begin
            errors++;
            $display("FAIL illegal_start_clear: err=%b want 0", err[0]);
        end
        run_window(0, z, 1);
        @(negedge clk);
        checks++;
        if (get_code(0) !== 0 || valid[0] !== 1'b1 || ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_window: code=%0d v=%b ovf=%b want 0 1 0", get_code(0), valid[0], ovf[0]);
        end
        consume(0);
    endtask

    task automatic test_ignored();
        int q[$];
        int exp;
        q = '{1, 1, rand_d(), rand_d()};
        exp = model(q);
        drive_stb(0, 1);
        @(negedge clk);
        drive_stb(0, -1);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_stb: busy=%b valid=%b want 0 0", busy[0], valid[0]);
        end
        start[0] = 1'b1;
        stb[0] = 1'b1;
        src_n[0] = 1'b1;
        snk[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        stb[0] = 1'b0;
        snk[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL ign_busy_rise: busy=%b want 1", busy[0]);
        end
        @(negedge clk);
        foreach (q[i]) begin
            drive_stb(0, q[i]);
            if (i == 1) pulse_start(0);
            else if (i != 3) @(negedge clk);
        end
        checks++;
        if (busy[0] !== 1'b1 || valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL ign_done_cycle: busy=%b valid=%b want 1 0", busy[0], valid[0]);
        end
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || valid[0] !== 1'b1 || get_code(0) !== exp) begin
            errors++;
            $display("FAIL ign_result: busy=%b valid=%b code=%0d want 0 1 %0d",
                     busy[0], valid[0], get_code(0), exp);
        end
        consume(0);
    endtask

    task automatic test_alternate();
        int q[$];
        int exp;
        for (int i = 0; i < 64; i++) q.push_back((i % 2 == 0) ? 1 : -1);
        exp = model(q);
        pulse_start(1);
        run_window(1, q, 1);
        @(negedge clk);
        checks++;
        if (valid[1] !== 1'b1 || get_code(1) !== exp) begin
            errors++;
            $display("FAIL alternate: valid=%b code=%0d want 1 %0d", valid[1], get_code(1), exp);
        end
        consume(1);
    endtask

    task automatic test_random();
        for (int w = 0; w < 3; w++) begin
            int q[$];
            int exp;
            for (int i = 0; i < 64; i++) q.push_back(rand_d());
            exp = model(q);
            pulse_start(1);
            run_window(1, q, 3);
            @(negedge clk);
            checks++;
            if (valid[1] !== 1'b1 || get_code(1) !== exp || busy[1] !== 1'b0) begin
                errors++;
                $display("FAIL random_w%0d: valid=%b busy=%b code=%0d want 1 0 %0d",
                         w, valid[1], busy[1], get_code(1), exp);
            end
            consume(1);
        end
    endtask

    task automatic test_continuous();
        int w1[$] = '{1, 1, 1, 1};
        int w2[$] = '{-1, -1, -1, -1};
        int w3[$];
        int w4[$];
        int e1 = model(w1);
        w3 = '{rand_d(), rand_d(), rand_d(), rand_d()};
        w4 = '{rand_d(), rand_d(), rand_d(), rand_d()};
        pulse_start(2);
        run_window(2, w1, 1);
        drive_stb(2, 1);
        checks++;
        if (valid[2] !== 1'b1 || get_code(2) !== e1 || busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL cont_w1: valid=%b busy=%b code=%0d want 1 1 %0d",
                     valid[2], busy[2], get_code(2), e1);
        end
        @(negedge clk);
        run_window(2, w2, 1);
        @(negedge clk);
        checks++;
        if (valid[2] !== 1'b1 || get_code(2) !== e1 || ovf[2] !== 1'b1) begin
            errors++;
            $display("FAIL cont_ovf: valid=%b ovf=%b code=%0d want 1 1 %0d",
                     valid[2], ovf[2], get_code(2), e1);
        end
        consume(2);
        rdy[2] = 1'b1;
        run_window(2, w3, 1);
        @(negedge clk);
        checks++;
        if (valid[2] !== 1'b1 || get_code(2) !== model(w3)) begin
            errors++;
            $display("FAIL cont_w3: valid=%b code=%0d want 1 %0d", valid[2], get_code(2), model(w3));
        end
        @(negedge clk);
        run_window(2, w4, 1);
        @(negedge clk);
        checks++;
        if (valid[2] !== 1'b1 || get_code(2) !== model(w4) || ovf[2] !== 1'b1) begin
            errors++;
            $display("FAIL cont_reload: valid=%b ovf=%b code=%0d want 1 1 %0d",
                     valid[2], ovf[2], get_code(2), model(w4));
        end
        rdy[2] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int p[$] = '{1, 1};
        int q[$] = '{-1, -1, -1, -1};
        int exp = model(q);
        pulse_start(0);
        run_window(0, p, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || valid[0] !== 1'b0 || ovf[2] !== 1'b0 || busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy0=%b valid0=%b ovf2=%b busy2=%b want 0 0 0 0",
                     busy[0], valid[0], ovf[2], busy[2]);
        end
        reset = 1'b0;
        @(negedge clk);
        pulse_start(0);
        run_window(0, q, 2);
        @(negedge clk);
        checks++;
        if (valid[0] !== 1'b1 || get_code(0) !== exp) begin
            errors++;
            $display("FAIL reset_fresh: valid=%b code=%0d want 1 %0d", valid[0], get_code(0), exp);
        end
        consume(0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_ignored();
        test_alternate();
        test_random();
        test_continuous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
